uart_cfg: RTL and testbench
===========================

UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 The block SHALL take parameter CLK_F, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD, default 115200, line bit rate.
REQ-003 The block SHALL take parameter DATA_W, default 8, data bits per frame, legal 5..8.
REQ-004 The block SHALL take parameter PARITY, default 0, with 0 = none, 1 = even, 2 = odd.
REQ-005 The block SHALL take parameter STOP_BITS, default 1, legal 1 or 2.
REQ-006 The block SHALL take parameter FIFO_DEPTH, default 16, entries per FIFO, power of 2, minimum 2.
REQ-007 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, the clock; rst_n in 1, the reset.
REQ-008 The block SHALL have the data ports: i_loopback in 1, loopback select; i_rx_serial_ext in 1, serial input; o_tx_serial_ext out 1, serial output.
REQ-009 The block SHALL have the TX-side ports: i_tx_data in DATA_W, write data; i_tx_valid in 1, write request; o_tx_ready out 1, TX FIFO not full; o_tx_busy out 1, frame in progress or TX FIFO non-empty.
REQ-010 The block SHALL have the RX-side ports: o_rx_data out DATA_W, RX FIFO head; o_rx_valid out 1, RX FIFO not empty; i_rx_ready in 1, pop.
REQ-011 The block SHALL have the status ports: o_parity_err out 1 and o_frame_err out 1, flags of the current head entry; o_rx_overflow out 1, sticky overflow; i_clear_err in 1, clears the overflow flag.

Function
REQ-012 The block SHALL generate a 16x oversample tick every DIV = round(CLK_F/(16*BAUD)) clk cycles; each line bit lasts exactly 16 ticks.
REQ-013 A TX write SHALL be accepted when i_tx_valid && o_tx_ready; a write while full is ignored.
REQ-014 The TX FSM SHALL use the states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY == 0; STOP lasts STOP_BITS bit times.
REQ-015 TX data SHALL go out LSB first; the parity bit is the XOR of the data bits for even parity and its inverse for odd parity.
REQ-016 TX timing: in IDLE with the FIFO non-empty, the FSM pops the FIFO, and the line falls 2 clk cycles after an accepted write to an empty idle block; the tick counter restarts at start-bit entry.
REQ-017 Back-to-back frames SHALL have no idle gap: STOP goes to START directly when the FIFO is non-empty.
REQ-018 The RX input SHALL pass through a 2-FF synchronizer; the RX FSM uses IDLE, START, DATA, PARITY, STOP.
REQ-019 RX start detection: a falling edge in IDLE starts tick counting; at tick 8 the line must still be low, otherwise the FSM returns to IDLE (glitch reject) and nothing is pushed.
REQ-020 RX sampling: data, parity and stop bits are sampled at mid-bit (tick 8 of each bit); only the first stop bit is checked.
REQ-021 RX push: each frame pushes {frame_err, parity_err, data} at the first-stop-bit sample; frame_err = stop sampled 0; parity_err = parity mismatch, forced 0 when PARITY == 0.
REQ-022 RX push while full SHALL drop the frame and set o_rx_overflow, unless i_rx_ready pops in the same cycle, in which case the push is accepted.
REQ-023 o_rx_overflow SHALL stay set until i_clear_err; if i_clear_err and a new overflow occur in the same cycle, set wins.
REQ-024 Pop: a pop occurs on o_rx_valid && i_rx_ready; o_rx_data and the error flags are valid whenever o_rx_valid is 1.
REQ-025 With i_loopback = 1, the RX input SHALL be taken from the internal TX line and o_tx_serial_ext is held at 1.
REQ-026 Changing i_loopback mid-frame is allowed; a corrupted frame is reported through the error flags only.

Reset
REQ-027 While rst_n = 0, the block SHALL hold: o_tx_serial_ext = 1, o_tx_ready = 1, o_tx_busy = 0, o_rx_valid = 0, o_rx_data = 0, all error flags 0, both FSMs in IDLE, FIFO pointers and tick counters 0.
REQ-028 A reset asserted mid-frame SHALL abort the frame immediately and discard all FIFO contents; there is no partial push.

Structure
REQ-029 Package uart_cfg_pkg SHALL hold the parity enum, the TX and RX state enums, and the divisor function.
REQ-030 There SHALL be one sub-module, uart_fifo (synchronous, parametrised width and depth, with full/empty outputs), instantiated once for TX with width DATA_W and once for RX with width DATA_W+2.

Verification (CLK_F = 50e6, BAUD = 115200, DIV = 27, bit = 432 cycles)
REQ-031 Loopback, PARITY = 1: write 0x55 -> o_rx_valid rises with o_rx_data = 0x55 and both error flags 0.
REQ-032 Normal mode, PARITY = 2, STOP_BITS = 2: write 0xA3 -> the line shows start 0, bits 1,1,0,0,0,1,0,1, parity 1, and two stop bits of 1, each exactly 432 cycles.
REQ-033 External RX frame 0x3C with stop bit driven 0 -> one entry with data 0x3C, o_frame_err = 1; a 100-cycle low glitch -> no entry.
REQ-034 Loopback, FIFO_DEPTH = 4: write 6 bytes 0x00..0x05 with no pops -> 4 entries 0x00..0x03, o_rx_overflow = 1, cleared by a single i_clear_err pulse.
REQ-035 rst_n pulsed low during DATA of frame 0x81 -> line is 1, o_rx_valid = 0, o_tx_ready = 1; no entry afterwards.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared types and helpers for the uart_cfg block
// Contents: parity_e (line parity mode), tx_state_e / rx_state_e (FSM states),
//           calc_div (clk cycles per 16x oversample tick, rounded to nearest).
package uart_cfg_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } parity_e;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_e;

   function automatic int calc_div(input int clk_f, input int baud);
      return (clk_f + 8 * baud) / (16 * baud);
   endfunction

endpackage

// File: rtl/uart_cfg_if.sv
// rtl/uart_cfg_if.sv - TX write / RX pop / status bundle of uart_cfg
// Signals: i_tx_data/i_tx_valid/o_tx_ready/o_tx_busy (TX write side),
//          o_rx_data/o_rx_valid/i_rx_ready (RX FIFO head and pop),
//          o_parity_err/o_frame_err (head flags), o_rx_overflow/i_clear_err.
// Modports: master = user of the UART, slave = uart_cfg.
interface uart_cfg_if
   import uart_cfg_pkg::*;
#(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] i_tx_data;
   logic              i_tx_valid;
   logic              o_tx_ready;
   logic              o_tx_busy;
   logic [DATA_W-1:0] o_rx_data;
   logic              o_rx_valid;
   logic              i_rx_ready;
   logic              o_parity_err;
   logic              o_frame_err;
   logic              o_rx_overflow;
   logic              i_clear_err;

   modport master (
      output i_tx_data, i_tx_valid, i_rx_ready, i_clear_err,
      input  o_tx_ready, o_tx_busy, o_rx_data, o_rx_valid,
             o_parity_err, o_frame_err, o_rx_overflow
   );

   modport slave (
      input  i_tx_data, i_tx_valid, i_rx_ready, i_clear_err,
      output o_tx_ready, o_tx_busy, o_rx_data, o_rx_valid,
             o_parity_err, o_frame_err, o_rx_overflow
   );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous FIFO, first-word-fall-through head
// Ports: clk, rst_n (async active-low), i_push/i_data write, i_pop read,
//        o_data (current head), o_full, o_empty.
module uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr_ptr;
   logic [AW:0]  r_rd_ptr;
   logic         w_pop_ok;
   logic         w_push_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_pop_ok  = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
   assign w_push_ok = i_push && (!o_full || w_pop_ok);
   assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/uart_cfg.sv
// rtl/uart_cfg.sv - configurable UART with TX/RX FIFOs and loopback
// Ports: clk, rst_n (async active-low); i_loopback routes the internal TX line
//        to RX and parks o_tx_serial_ext high; i_rx_serial_ext serial input;
//        bus (uart_cfg_if.slave) carries the TX write, RX pop and status signals.
module uart_cfg
   import uart_cfg_pkg::*;
#(
   parameter int CLK_F      = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int DATA_W     = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_loopback,
   input  logic      i_rx_serial_ext,
   output logic      o_tx_serial_ext,
   uart_cfg_if.slave bus
);
   localparam int               DIV      = calc_div(CLK_F, BAUD);
   localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
   localparam int               BIT_W    = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam parity_e          PAR_MODE = (PARITY == 1) ? PAR_EVEN :
                                           (PARITY == 2) ? PAR_ODD : PAR_NONE;
   localparam logic             PAR_ON   = (PAR_MODE != PAR_NONE);
   localparam logic             PAR_INV  = (PAR_MODE == PAR_ODD);

   // ---------------- TX ----------------
   logic              w_tx_push, w_tx_full, w_tx_empty;
   logic [DATA_W-1:0] w_tx_head;
   tx_state_e         r_tx_state, w_tx_state_nxt;
   logic [DIV_W-1:0]  r_tx_div;
   logic [3:0]        r_tx_tick;
   logic [DATA_W-1:0] r_tx_shift;
   logic [BIT_W-1:0]  r_tx_bit;
   logic              r_tx_par, r_tx_stop, r_tx_line;
   logic              w_tx_bit_end, w_tx_load, w_tx_shift_en, w_tx_line_nxt;

   assign w_tx_push = bus.i_tx_valid && !w_tx_full;

   uart_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(w_tx_push), .i_data(bus.i_tx_data),
      .i_pop(w_tx_load), .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty)
   );

   assign w_tx_bit_end = (r_tx_div == DIV_LAST) && (r_tx_tick == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tx_state <= TX_IDLE;
      else        r_tx_state <= w_tx_state_nxt;
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_load      = 1'b0;
      w_tx_shift_en  = 1'b0;
      w_tx_line_nxt  = 1'b1;
      case (r_tx_state)
         TX_IDLE: if (!w_tx_empty) begin
            w_tx_load      = 1'b1;
            w_tx_state_nxt = TX_START;
         end
         TX_START: begin
            w_tx_line_nxt = 1'b0;
            if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
         end
         TX_DATA: begin
            w_tx_line_nxt = r_tx_shift[0];
            if (w_tx_bit_end) begin
               w_tx_shift_en = 1'b1;
               if (r_tx_bit == BIT_LAST) w_tx_state_nxt = PAR_ON ? TX_PARITY : TX_STOP;
            end
         end
         TX_PARITY: begin
            w_tx_line_nxt = r_tx_par;
            if (w_tx_bit_end) w_tx_state_nxt = TX_STOP;
         end
         TX_STOP: if (w_tx_bit_end && ((STOP_BITS == 1) || r_tx_stop)) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!w_tx_empty) begin
               w_tx_load      = 1'b1;
               w_tx_state_nxt = TX_START;
            end else begin
               w_tx_state_nxt = TX_IDLE;
            end
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
   end

   // The line is registered from the state, so it lags the state by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_div   <= '0;
         r_tx_tick  <= '0;
         r_tx_shift <= '0;
         r_tx_bit   <= '0;
         r_tx_par   <= 1'b0;
         r_tx_stop  <= 1'b0;
         r_tx_line  <= 1'b1;
      end else begin
         r_tx_line <= w_tx_line_nxt;
         if (w_tx_load) begin
            r_tx_div   <= '0;
            r_tx_tick  <= '0;
            r_tx_shift <= w_tx_head;
            r_tx_bit   <= '0;
            r_tx_par   <= ^w_tx_head ^ PAR_INV;
            r_tx_stop  <= 1'b0;
         end else if (r_tx_state != TX_IDLE) begin
            r_tx_div <= (r_tx_div == DIV_LAST) ? '0 : r_tx_div + 1'b1;
            if (r_tx_div == DIV_LAST) r_tx_tick <= r_tx_tick + 1'b1;
            if (w_tx_shift_en) begin
               r_tx_shift <= r_tx_shift >> 1;
               r_tx_bit   <= r_tx_bit + 1'b1;
            end
            if (w_tx_bit_end && (r_tx_state == TX_STOP)) r_tx_stop <= 1'b1;
         end
      end
   end

   assign o_tx_serial_ext = i_loopback ? 1'b1 : r_tx_line;
   assign bus.o_tx_ready  = !w_tx_full;
   assign bus.o_tx_busy   = (r_tx_state != TX_IDLE) || !w_tx_empty;

   // ---------------- RX ----------------
   logic              r_rx_sync1, r_rx_sync2, r_rx_prev;
   rx_state_e         r_rx_state, w_rx_state_nxt;
   logic [DIV_W-1:0]  r_rx_div;
   logic [3:0]        r_rx_tick;
   logic [DATA_W-1:0] r_rx_shift;
   logic [BIT_W-1:0]  r_rx_bit;
   logic              r_rx_par, r_rx_ovf;
   logic              w_rx_mid, w_rx_bit_end, w_rx_sample, w_rx_par_sample, w_rx_push;
   logic              w_rx_par_err, w_rx_pop, w_rx_full, w_rx_empty;
   logic [DATA_W+1:0] w_rx_entry, w_rx_head;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_sync1 <= 1'b1;
         r_rx_sync2 <= 1'b1;
         r_rx_prev  <= 1'b1;
      end else begin
         r_rx_sync1 <= i_loopback ? r_tx_line : i_rx_serial_ext;
         r_rx_sync2 <= r_rx_sync1;
         r_rx_prev  <= r_rx_sync2;
      end
   end

   assign w_rx_mid     = (r_rx_div == DIV_LAST) && (r_rx_tick == 4'd7);
   assign w_rx_bit_end = (r_rx_div == DIV_LAST) && (r_rx_tick == 4'd15);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_state <= RX_IDLE;
      else        r_rx_state <= w_rx_state_nxt;
   end

   always_comb begin
      w_rx_state_nxt  = r_rx_state;
      w_rx_sample     = 1'b0;
      w_rx_par_sample = 1'b0;
      w_rx_push       = 1'b0;
      case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !r_rx_sync2) w_rx_state_nxt = RX_START;
         RX_START: begin
            if (w_rx_mid && r_rx_sync2) w_rx_state_nxt = RX_IDLE;  // glitch reject
            else if (w_rx_bit_end)      w_rx_state_nxt = RX_DATA;
         end
         RX_DATA: begin
            w_rx_sample = w_rx_mid;
            if (w_rx_bit_end && (r_rx_bit == BIT_LAST))
               w_rx_state_nxt = PAR_ON ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: begin
            w_rx_par_sample = w_rx_mid;
            if (w_rx_bit_end) w_rx_state_nxt = RX_STOP;
         end
         RX_STOP: if (w_rx_mid) begin
            // Only the first stop bit is checked; back to IDLE to catch the next start.
            w_rx_push      = 1'b1;
            w_rx_state_nxt = RX_IDLE;
         end
         default: w_rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_div   <= '0;
         r_rx_tick  <= '0;
         r_rx_shift <= '0;
         r_rx_bit   <= '0;
         r_rx_par   <= 1'b0;
      end else begin
         if ((r_rx_state == RX_IDLE) || (w_rx_state_nxt == RX_IDLE)) begin
            r_rx_div  <= '0;
            r_rx_tick <= '0;
         end else begin
            r_rx_div <= (r_rx_div == DIV_LAST) ? '0 : r_rx_div + 1'b1;
            if (r_rx_div == DIV_LAST) r_rx_tick <= r_rx_tick + 1'b1;
         end
         if (r_rx_state == RX_START) r_rx_bit <= '0;
         else if ((r_rx_state == RX_DATA) && w_rx_bit_end) r_rx_bit <= r_rx_bit + 1'b1;
         if (w_rx_sample)     r_rx_shift <= {r_rx_sync2, r_rx_shift[DATA_W-1:1]};
         if (w_rx_par_sample) r_rx_par   <= r_rx_sync2;
      end
   end

   assign w_rx_par_err = PAR_ON && (r_rx_par != (^r_rx_shift ^ PAR_INV));
   assign w_rx_entry   = {~r_rx_sync2, w_rx_par_err, r_rx_shift};
   assign w_rx_pop     = bus.i_rx_ready && !w_rx_empty;

   uart_fifo #(.W(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk(clk), .rst_n(rst_n), .i_push(w_rx_push), .i_data(w_rx_entry),
      .i_pop(w_rx_pop), .o_data(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty)
   );

   // Set has priority over clear when both happen in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                  r_rx_ovf <= 1'b0;
      else if (w_rx_push && w_rx_full && !w_rx_pop) r_rx_ovf <= 1'b1;
      else if (bus.i_clear_err)                     r_rx_ovf <= 1'b0;
   end

   assign bus.o_rx_valid    = !w_rx_empty;
   assign bus.o_rx_data     = w_rx_empty ? '0 : w_rx_head[DATA_W-1:0];
   assign bus.o_parity_err  = !w_rx_empty && w_rx_head[DATA_W];
   assign bus.o_frame_err   = !w_rx_empty && w_rx_head[DATA_W+1];
   assign bus.o_rx_overflow = r_rx_ovf;
endmodule

// File: tb/tb_uart_cfg.sv
// tb/tb_uart_cfg.sv - directed self-checking bench for uart_cfg
// Three instances: a = even parity / loopback, b = odd parity + 2 stop / external,
// c = no parity, FIFO depth 4, loopback.
module tb_uart_cfg;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic lb_a, lb_b, lb_c;
   logic rx_a, rx_b, rx_c;
   logic tx_a, tx_b, tx_c;

   uart_cfg_if #(.DATA_W(8)) ifa ();
   uart_cfg_if #(.DATA_W(8)) ifb ();
   uart_cfg_if #(.DATA_W(8)) ifc ();

   uart_cfg #(.PARITY(1)) dut_a (
      .clk(clk), .rst_n(rst_a), .i_loopback(lb_a), .i_rx_serial_ext(rx_a),
      .o_tx_serial_ext(tx_a), .bus(ifa)
   );
   uart_cfg #(.PARITY(2), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst_n(rst_b), .i_loopback(lb_b), .i_rx_serial_ext(rx_b),
      .o_tx_serial_ext(tx_b), .bus(ifb)
   );
   uart_cfg #(.PARITY(0), .FIFO_DEPTH(4)) dut_c (
      .clk(clk), .rst_n(rst_c), .i_loopback(lb_c), .i_rx_serial_ext(rx_c),
      .o_tx_serial_ext(tx_c), .bus(ifc)
   );

   int   errors = 0;
   int   checks = 0;
   int   bad;
   logic b_exp [12];

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One external frame into dut_b: start, 8 data LSB first, parity, one stop, then idle.
   task automatic send_b(input logic [7:0] d, input logic par, input logic stop);
      rx_b = 1'b0;
      tick(432);
      for (int i = 0; i < 8; i++) begin
         rx_b = d[i];
         tick(432);
      end
      rx_b = par;
      tick(432);
      rx_b = stop;
      tick(432);
      rx_b = 1'b1;
      tick(20);
   endtask

   task automatic pop_b();
      ifb.i_rx_ready = 1'b1;
      tick();
      ifb.i_rx_ready = 1'b0;
   endtask

   initial begin
      rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
      lb_a = 1'b1; lb_b = 1'b0; lb_c = 1'b1;
      rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
      ifa.i_tx_data = '0; ifa.i_tx_valid = 1'b0; ifa.i_rx_ready = 1'b0; ifa.i_clear_err = 1'b0;
      ifb.i_tx_data = '0; ifb.i_tx_valid = 1'b0; ifb.i_rx_ready = 1'b0; ifb.i_clear_err = 1'b0;
      ifc.i_tx_data = '0; ifc.i_tx_valid = 1'b0; ifc.i_rx_ready = 1'b0; ifc.i_clear_err = 1'b0;
      b_exp = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      tick(3);

      // Reset state
      check("rst_b_line", tx_b, 1);
      check("rst_b_ready", ifb.o_tx_ready, 1);
      check("rst_b_busy", ifb.o_tx_busy, 0);
      check("rst_b_rx_valid", ifb.o_rx_valid, 0);
      check("rst_b_rx_data", ifb.o_rx_data, 0);
      check("rst_b_flags", {ifb.o_parity_err, ifb.o_frame_err, ifb.o_rx_overflow}, 0);
      check("rst_c_line", tx_c, 1);
      rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
      tick(2);

      // Loopback, even parity, 0x55
      ifa.i_tx_data = 8'h55; ifa.i_tx_valid = 1'b1;
      tick();
      ifa.i_tx_valid = 1'b0;
      check("a_busy_after_write", ifa.o_tx_busy, 1);
      tick(1000);
      check("a_lb_ext_line_high", tx_a, 1);
      for (int n = 0; n < 6000 && !ifa.o_rx_valid; n++) tick();
      check("a_rx_valid", ifa.o_rx_valid, 1);
      check("a_rx_data", ifa.o_rx_data, 8'h55);
      check("a_parity_err", ifa.o_parity_err, 0);
      check("a_frame_err", ifa.o_frame_err, 0);
      ifa.i_rx_ready = 1'b1;
      tick();
      ifa.i_rx_ready = 1'b0;
      check("a_rx_empty_after_pop", ifa.o_rx_valid, 0);
      for (int n = 0; n < 2000 && ifa.o_tx_busy; n++) tick();
      check("a_busy_done", ifa.o_tx_busy, 0);

      // Normal mode, odd parity, 2 stop bits, 0xA3 on the line
      ifb.i_tx_data = 8'hA3; ifb.i_tx_valid = 1'b1;
      tick();
      ifb.i_tx_valid = 1'b0;
      tick();
      check("b_line_one_cycle_after", tx_b, 1);
      tick();
      check("b_line_fall_two_cycles", tx_b, 0);
      for (int b = 0; b < 12; b++) begin
         bad = 0;
         for (int c = 0; c < 432; c++) begin
            if (tx_b !== b_exp[b]) bad++;
            tick();
         end
         check($sformatf("b_bit%0d_cycles_wrong", b), bad, 0);
      end
      check("b_line_idle_after", tx_b, 1);
      check("b_busy_after", ifb.o_tx_busy, 0);

      // External RX into dut_b: frame error, parity error, glitch, clean frame
      send_b(8'h3C, 1'b1, 1'b0);
      check("b_ferr_valid", ifb.o_rx_valid, 1);
      check("b_ferr_data", ifb.o_rx_data, 8'h3C);
      check("b_ferr_frame", ifb.o_frame_err, 1);
      check("b_ferr_parity", ifb.o_parity_err, 0);
      pop_b();
      check("b_ferr_popped", ifb.o_rx_valid, 0);
      send_b(8'h3C, 1'b0, 1'b1);
      check("b_perr_data", ifb.o_rx_data, 8'h3C);
      check("b_perr_parity", ifb.o_parity_err, 1);
      check("b_perr_frame", ifb.o_frame_err, 0);
      pop_b();
      rx_b = 1'b0;
      tick(100);
      rx_b = 1'b1;
      tick(1000);
      check("b_glitch_no_entry", ifb.o_rx_valid, 0);
      send_b(8'h81, 1'b1, 1'b1);
      check("b_good_valid", ifb.o_rx_valid, 1);
      check("b_good_data", ifb.o_rx_data, 8'h81);
      check("b_good_flags", {ifb.o_parity_err, ifb.o_frame_err}, 0);
      pop_b();

      // Loopback, depth 4: six writes, four kept, overflow sticky until clear
      check("c_lb_ext_line", tx_c, 1);
      for (int i = 0; i < 6; i++) begin
         for (int n = 0; n < 6000 && !ifc.o_tx_ready; n++) tick();
         ifc.i_tx_data = 8'(i); ifc.i_tx_valid = 1'b1;
         tick();
         ifc.i_tx_valid = 1'b0;
      end
      for (int n = 0; n < 40000 && ifc.o_tx_busy; n++) tick();
      tick(20);
      check("c_tx_drained", ifc.o_tx_busy, 0);
      check("c_overflow_set", ifc.o_rx_overflow, 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("c_entry%0d_valid", i), ifc.o_rx_valid, 1);
         check($sformatf("c_entry%0d_data", i), ifc.o_rx_data, i);
         ifc.i_rx_ready = 1'b1;
         tick();
         ifc.i_rx_ready = 1'b0;
      end
      check("c_empty_after_4", ifc.o_rx_valid, 0);
      check("c_overflow_still_set", ifc.o_rx_overflow, 1);
      ifc.i_clear_err = 1'b1;
      tick();
      ifc.i_clear_err = 1'b0;
      check("c_overflow_cleared", ifc.o_rx_overflow, 0);

      // Reset in the middle of frame 0x81 (data bit 3 = 0 on the line)
      ifa.i_tx_data = 8'h81; ifa.i_tx_valid = 1'b1;
      tick();
      ifa.i_tx_valid = 1'b0;
      tick(1900);
      lb_a = 1'b0;
      tick(2);
      check("a_mid_frame_bit3", tx_a, 0);
      check("a_mid_frame_busy", ifa.o_tx_busy, 1);
      rst_a = 1'b0;
      #1;
      check("a_rst_line", tx_a, 1);
      check("a_rst_rx_valid", ifa.o_rx_valid, 0);
      check("a_rst_ready", ifa.o_tx_ready, 1);
      check("a_rst_busy", ifa.o_tx_busy, 0);
      tick(2);
      rst_a = 1'b1;
      lb_a = 1'b1;
      tick(6000);
      check("a_no_entry_after_rst", ifa.o_rx_valid, 0);
      check("a_idle_after_rst", ifa.o_tx_busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
